// File: rtl/fpu_align_stage_if.sv
// Handshake and payload bundle for the FPU pre-adder alignment stage.
// The slave side is the stage itself; the master side is its upstream/downstream environment.
interface fpu_align_stage_if #(
  parameter int GRS_BITS = 3
);
  localparam int MW = 24 + GRS_BITS;

  logic          InValid;
  logic          InReady;
  logic [31:0]   Operand1;
  logic [31:0]   Operand2;
  logic          Operation;
  logic          OutValid;
  logic          OutReady;
  logic          BigSign;
  logic          SmallSign;
  logic          EffSub;
  logic [7:0]    BigExp;
  logic [MW-1:0] BigMant;
  logic [MW-1:0] SmallMant;
  logic          Special;
  logic [31:0]   SpecialResult;

  modport slave (
    input  InValid, Operand1, Operand2, Operation, OutReady,
    output InReady, OutValid, BigSign, SmallSign, EffSub, BigExp,
           BigMant, SmallMant, Special, SpecialResult
  );

  modport master (
    output InValid, Operand1, Operand2, Operation, OutReady,
    input  InReady, OutValid, BigSign, SmallSign, EffSub, BigExp,
           BigMant, SmallMant, Special, SpecialResult
  );
endinterface

// File: rtl/fpu_align_stage.sv
// Two-stage FPU pre-adder: classify/order operands, then right-align the smaller significand with sticky.
// Define FPU_ALIGN_DAZ_EN to treat exp==0 operands as signed zero (denormals-are-zero).
module fpu_align_stage #(
  parameter int          GRS_BITS     = 3,
  parameter logic [31:0] QNAN_PATTERN = 32'h7FC00000
) (
  input logic CLK,
  input logic RST,
  fpu_align_stage_if.slave bus
);
  localparam int         MW     = 24 + GRS_BITS;
  localparam logic [7:0] MW_EXP = 8'(MW);

  logic en1, en2, v1, v2;

  assign en2          = !v2 || bus.OutReady;
  assign en1          = !v1 || en2;
  assign bus.InReady  = en1;
  assign bus.OutValid = v2;

  // ---------------- stage 1: classify and order ----------------
  logic        sign_a, sign_b;
  logic [7:0]  exp_a, exp_b;
  logic [22:0] frac_a, frac_b;

  always_comb begin
    sign_a = bus.Operand1[31];
    sign_b = bus.Operand2[31] ^ bus.Operation;
    exp_a  = bus.Operand1[30:23];
    exp_b  = bus.Operand2[30:23];
`ifdef FPU_ALIGN_DAZ_EN
    frac_a = (exp_a == 8'd0) ? 23'd0 : bus.Operand1[22:0];
    frac_b = (exp_b == 8'd0) ? 23'd0 : bus.Operand2[22:0];
`else
    frac_a = bus.Operand1[22:0];
    frac_b = bus.Operand2[22:0];
`endif
  end

  logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

  assign nan_a  = (&exp_a) && (|frac_a);
  assign nan_b  = (&exp_b) && (|frac_b);
  assign inf_a  = (&exp_a) && !(|frac_a);
  assign inf_b  = (&exp_b) && !(|frac_b);
  assign zero_a = !(|exp_a) && !(|frac_a);
  assign zero_b = !(|exp_b) && !(|frac_b);

  logic        swap;
  logic        big_sign, small_sign;
  logic [7:0]  big_raw_exp, small_raw_exp, big_eff_exp, small_eff_exp, diff;
  logic [23:0] big_sig, small_sig;

  // Ties keep A as the big operand.
  assign swap          = {exp_b, frac_b} > {exp_a, frac_a};
  assign big_sign      = swap ? sign_b : sign_a;
  assign small_sign    = swap ? sign_a : sign_b;
  assign big_raw_exp   = swap ? exp_b : exp_a;
  assign small_raw_exp = swap ? exp_a : exp_b;
  assign big_sig       = {|big_raw_exp, swap ? frac_b : frac_a};
  assign small_sig     = {|small_raw_exp, swap ? frac_a : frac_b};
  assign big_eff_exp   = (big_raw_exp == 8'd0) ? 8'd1 : big_raw_exp;
  assign small_eff_exp = (small_raw_exp == 8'd0) ? 8'd1 : small_raw_exp;
  assign diff          = big_eff_exp - small_eff_exp;

  logic        special;
  logic [31:0] special_result;

  always_comb begin
    special        = 1'b1;
    special_result = 32'd0;
    if (nan_a || nan_b) begin
      special_result = QNAN_PATTERN;
    end else if (inf_a && inf_b && (sign_a != sign_b)) begin
      special_result = QNAN_PATTERN;
    end else if (inf_a) begin
      special_result = {sign_a, 8'hFF, 23'd0};
    end else if (inf_b) begin
      special_result = {sign_b, 8'hFF, 23'd0};
    end else if (zero_a && zero_b) begin
      special_result = {sign_a & sign_b, 31'd0};
    end else begin
      special = 1'b0;
    end
  end

  logic        s1_big_sign, s1_small_sign, s1_special;
  logic [7:0]  s1_big_exp, s1_diff;
  logic [23:0] s1_big_sig, s1_small_sig;
  logic [31:0] s1_special_result;

  // ---------------- stage 2: align with sticky ----------------
  logic [MW-1:0] small_ext, lost_mask, aligned;

  assign small_ext = {s1_small_sig, {GRS_BITS{1'b0}}};
  assign lost_mask = ~({MW{1'b1}} << s1_diff);

  always_comb begin
    if (s1_diff >= MW_EXP) begin
      aligned = {{(MW-1){1'b0}}, |small_ext};
    end else begin
      aligned = (small_ext >> s1_diff) | {{(MW-1){1'b0}}, |(small_ext & lost_mask)};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      v1                <= 1'b0;
      v2                <= 1'b0;
      s1_big_sign       <= 1'b0;
      s1_small_sign     <= 1'b0;
      s1_special        <= 1'b0;
      s1_big_exp        <= 8'd0;
      s1_diff           <= 8'd0;
      s1_big_sig        <= 24'd0;
      s1_small_sig      <= 24'd0;
      s1_special_result <= 32'd0;
      bus.BigSign       <= 1'b0;
      bus.SmallSign     <= 1'b0;
      bus.EffSub        <= 1'b0;
      bus.BigExp        <= 8'd0;
      bus.BigMant       <= '0;
      bus.SmallMant     <= '0;
      bus.Special       <= 1'b0;
      bus.SpecialResult <= 32'd0;
    end else begin
      if (en1) begin
        v1 <= bus.InValid;
        if (bus.InValid) begin
          s1_big_sign       <= big_sign;
          s1_small_sign     <= small_sign;
          s1_special        <= special;
          s1_special_result <= special_result;
          s1_diff           <= diff;
          // Zeroing the significands here makes the aligner produce 0 for specials.
          s1_big_exp        <= special ? 8'd0 : big_eff_exp;
          s1_big_sig        <= special ? 24'd0 : big_sig;
          s1_small_sig      <= special ? 24'd0 : small_sig;
        end
      end
      if (en2) begin
        v2 <= v1;
        if (v1) begin
          bus.BigSign       <= s1_big_sign;
          bus.SmallSign     <= s1_small_sign;
          bus.EffSub        <= s1_big_sign ^ s1_small_sign;
          bus.BigExp        <= s1_big_exp;
          bus.BigMant       <= {s1_big_sig, {GRS_BITS{1'b0}}};
          bus.SmallMant     <= aligned;
          bus.Special       <= s1_special;
          bus.SpecialResult <= s1_special_result;
        end
      end
    end
  end
endmodule

// File: tb/tb_fpu_align_stage.sv
// Randomized scoreboard bench for fpu_align_stage plus directed corner cases.
module tb_fpu_align_stage;
  localparam int GRS = 3;
  localparam int MW  = 24 + GRS;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;
  int   out_count = 0;

  always #5 CLK = ~CLK;

  fpu_align_stage_if #(.GRS_BITS(GRS)) bus ();
  fpu_align_stage #(.GRS_BITS(GRS)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  typedef struct packed {
    logic        bs;
    logic        ss;
    logic        es;
    logic [7:0]  be;
    logic [26:0] bm;
    logic [26:0] sm;
    logic        sp;
    logic [31:0] sr;
  } exp_t;

  exp_t sb[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, expv, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic op);
    exp_t   r;
    int     ea, eb, be, se, d;
    longint fa, fb, bf, sf, bm, smx, sm, p;
    logic   sa, sbn, swap, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    sa  = a[31];
    sbn = b[31] ^ op;
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    fa  = longint'(a[22:0]);
    fb  = longint'(b[22:0]);
`ifdef FPU_ALIGN_DAZ_EN
    if (ea == 0) fa = 0;
    if (eb == 0) fb = 0;
`endif
    nan_a  = (ea == 255) && (fa != 0);
    nan_b  = (eb == 255) && (fb != 0);
    inf_a  = (ea == 255) && (fa == 0);
    inf_b  = (eb == 255) && (fb == 0);
    zero_a = (ea == 0) && (fa == 0);
    zero_b = (eb == 0) && (fb == 0);
    swap = (longint'(eb) * 8388608 + fb) > (longint'(ea) * 8388608 + fa);
    be = swap ? eb : ea;
    se = swap ? ea : eb;
    bf = swap ? fb : fa;
    sf = swap ? fa : fb;
    bm  = ((be != 0) ? 8388608 : 0) + bf;
    smx = (((se != 0) ? 8388608 : 0) + sf) * 8;
    bm  = bm * 8;
    be  = (be == 0) ? 1 : be;
    se  = (se == 0) ? 1 : se;
    d   = be - se;
    if (d >= MW) begin
      sm = (smx != 0) ? 1 : 0;
    end else begin
      p = 1;
      for (int i = 0; i < d; i++) p = p * 2;
      sm = (smx / p) + (((smx % p) != 0 && ((smx / p) % 2) == 0) ? 1 : 0);
    end
    r.bs = swap ? sbn : sa;
    r.ss = swap ? sa : sbn;
    r.es = r.bs ^ r.ss;
    r.be = 8'(be);
    r.bm = 27'(bm);
    r.sm = 27'(sm);
    r.sp = 1'b1;
    if (nan_a || nan_b)                  r.sr = 32'h7FC00000;
    else if (inf_a && inf_b && sa != sbn) r.sr = 32'h7FC00000;
    else if (inf_a)                      r.sr = {sa, 8'hFF, 23'd0};
    else if (inf_b)                      r.sr = {sbn, 8'hFF, 23'd0};
    else if (zero_a && zero_b)           r.sr = {sa & sbn, 31'd0};
    else begin
      r.sp = 1'b0;
      r.sr = 32'd0;
    end
    if (r.sp) begin
      r.be = 8'd0;
      r.bm = 27'd0;
      r.sm = 27'd0;
    end
    return r;
  endfunction

  // Scoreboard: sample handshakes mid-cycle, after the drivers have settled.
  always @(negedge CLK) begin
    exp_t e;
    #2;
    if (RST) begin
      sb.delete();
    end else begin
      if (bus.OutValid && bus.OutReady) begin
        out_count++;
        check_val("sb_avail", 64'(sb.size() > 0), 64'(1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_val("signs", 64'({bus.BigSign, bus.SmallSign, bus.EffSub}), 64'({e.bs, e.ss, e.es}));
          check_val("big_exp", 64'(bus.BigExp), 64'(e.be));
          check_val("big_mant", 64'(bus.BigMant), 64'(e.bm));
          check_val("small_mant", 64'(bus.SmallMant), 64'(e.sm));
          check_val("special", 64'(bus.Special), 64'(e.sp));
          check_val("special_result", 64'(bus.SpecialResult), 64'(e.sr));
        end
      end
      if (bus.InValid && bus.InReady) sb.push_back(model(bus.Operand1, bus.Operand2, bus.Operation));
    end
  end

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic op);
    @(negedge CLK);
    bus.Operand1 = a;
    bus.Operand2 = b;
    bus.Operation = op;
    bus.InValid = 1'b1;
    bus.OutReady = 1'b1;
    @(negedge CLK);
    bus.InValid = 1'b0;
    @(negedge CLK);
    #3;
    check_val("latency_valid", 64'(bus.OutValid), 64'(1));
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0: v[30:0] = 31'd0;
      1: v[30:0] = {8'hFF, 23'd0};
      2: v[30:23] = 8'hFF;
      3: v[30:23] = 8'h00;
      4: v = v;
      default: v[30:23] = 8'($urandom_range(100, 160));
    endcase
    return v;
  endfunction

  initial begin
    exp_t e1;
    int   base;
    RST = 1'b1;
    bus.InValid = 1'b0;
    bus.Operand1 = 32'd0;
    bus.Operand2 = 32'd0;
    bus.Operation = 1'b0;
    bus.OutReady = 1'b0;
    repeat (3) @(negedge CLK);
    #3;
    check_val("rst_outvalid", 64'(bus.OutValid), 64'(0));
    check_val("rst_bigmant", 64'(bus.BigMant), 64'(0));
    check_val("rst_specres", 64'(bus.SpecialResult), 64'(0));
    RST = 1'b0;
    @(negedge CLK);
    #3;
    check_val("rst_inready", 64'(bus.InReady), 64'(1));

    run_one(32'h46BFCA0A, 32'h424BEB85, 1'b0);
    check_val("t1_exp", 64'(bus.BigExp), 64'h8D);
    check_val("t1_bmant", 64'(bus.BigMant), 64'h5FE5050);
    check_val("t1_smant", 64'(bus.SmallMant), 64'h0032FAF);
    check_val("t1_effsub", 64'(bus.EffSub), 64'(0));
    check_val("t1_special", 64'(bus.Special), 64'(0));

    run_one(32'h3F800000, 32'h3F800000, 1'b1);
    check_val("t2_signs", 64'({bus.BigSign, bus.SmallSign, bus.EffSub}), 64'b011);
    check_val("t2_bmant", 64'(bus.BigMant), 64'h4000000);
    check_val("t2_smant", 64'(bus.SmallMant), 64'h4000000);
    check_val("t2_exp", 64'(bus.BigExp), 64'h7F);

    run_one(32'h4B800000, 32'h3F800001, 1'b0);
    check_val("t3_d24", 64'(bus.SmallMant), 64'h5);
    run_one(32'h4F800000, 32'h3F800000, 1'b0);
    check_val("t3_d32", 64'(bus.SmallMant), 64'h1);

    run_one(32'h7F800000, 32'h7F800000, 1'b1);
    check_val("t4_special", 64'(bus.Special), 64'(1));
    check_val("t4_qnan", 64'(bus.SpecialResult), 64'h7FC00000);
    check_val("t4_zero_mant", 64'(bus.BigMant), 64'(0));
    run_one(32'hFF800000, 32'h3F800000, 1'b0);
    check_val("t4_ninf", 64'(bus.SpecialResult), 64'hFF800000);

    // Backpressure: three pairs against a stalled output.
    @(negedge CLK);
    bus.OutReady = 1'b0;
    bus.Operand1 = 32'h40400000; bus.Operand2 = 32'h3F000000; bus.Operation = 1'b0;
    bus.InValid = 1'b1;
    e1 = model(32'h40400000, 32'h3F000000, 1'b0);
    #1 check_val("bp_rdy1", 64'(bus.InReady), 64'(1));
    @(negedge CLK);
    bus.Operand1 = 32'hC1200000; bus.Operand2 = 32'h41A00000; bus.Operation = 1'b1;
    #1 check_val("bp_rdy2", 64'(bus.InReady), 64'(1));
    @(negedge CLK);
    bus.Operand1 = 32'h3E800000; bus.Operand2 = 32'h44800000; bus.Operation = 1'b0;
    #1 check_val("bp_rdy3", 64'(bus.InReady), 64'(0));
    base = out_count;
    repeat (2) begin
      @(negedge CLK);
      #3;
      check_val("bp_hold_valid", 64'(bus.OutValid), 64'(1));
      check_val("bp_hold_mant", 64'(bus.SmallMant), 64'(e1.sm));
      check_val("bp_hold_rdy", 64'(bus.InReady), 64'(0));
    end
    @(negedge CLK);
    bus.OutReady = 1'b1;
    @(negedge CLK);
    bus.InValid = 1'b0;
    repeat (4) @(negedge CLK);
    #3;
    check_val("bp_count", 64'(out_count - base), 64'(3));

    // Reset with two transactions in flight.
    @(negedge CLK);
    bus.OutReady = 1'b0;
    bus.Operand1 = 32'h40000000; bus.Operand2 = 32'h40400000; bus.Operation = 1'b0;
    bus.InValid = 1'b1;
    @(negedge CLK);
    bus.Operand1 = 32'h41000000;
    @(negedge CLK);
    bus.InValid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #3;
    check_val("rstf_outvalid", 64'(bus.OutValid), 64'(0));
    base = out_count;
    bus.OutReady = 1'b1;
    repeat (4) @(negedge CLK);
    #3;
    check_val("rstf_no_emit", 64'(out_count - base), 64'(0));

    run_one(32'h3F800000, 32'hC0000000, 1'b1);
    check_val("sw_bsign", 64'(bus.BigSign), 64'(0));
    check_val("sw_exp", 64'(bus.BigExp), 64'h80);
    check_val("sw_ssign", 64'(bus.SmallSign), 64'(0));

    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      bus.InValid  = ($urandom_range(0, 3) != 0);
      bus.OutReady = ($urandom_range(0, 3) != 0);
      bus.Operand1 = rand_op();
      bus.Operand2 = rand_op();
      bus.Operation = 1'($urandom_range(0, 1));
    end
    @(negedge CLK);
    bus.InValid = 1'b0;
    bus.OutReady = 1'b1;
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge CLK);
    #3;
    check_val("drain_empty", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_align_stage.md
Name: fpu_align_stage

Overview:
- Front-end pre-adder stage that sits directly upstream of the FPU add/sub datapath.
- Accepts two IEEE-754 single-precision operands plus an add/sub select, classifies them, and filters out special cases.
- Orders the operands by magnitude and right-aligns the smaller significand, producing guard/round/sticky bits.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- GRS_BITS, 3, number of extra low-order significand bits (guard, round, sticky); mantissa output width MW = 24+GRS_BITS.
- QNAN_PATTERN, 32'h7FC00000, canonical quiet NaN emitted on invalid operations.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous reset, active-high.
- InValid  input  1  an operand pair is presented.
- InReady  output  1  stage accepts the pair this cycle.
- Operand1  input  32  IEEE-754 single operand A.
- Operand2  input  32  IEEE-754 single operand B.
- Operation  input  1  0 = A+B, 1 = A-B.
- OutValid  output  1  aligned result is valid.
- OutReady  input  1  downstream consumes the result this cycle.
- BigSign  output  1  sign of the larger-magnitude operand, after the subtract flip.
- SmallSign  output  1  sign of the smaller-magnitude operand, after the subtract flip.
- EffSub  output  1  BigSign XOR SmallSign.
- BigExp  output  8  biased exponent of the larger operand; a denormal reports 1.
- BigMant  output  MW  {hidden, frac[22:0], GRS zeros}.
- SmallMant  output  MW  smaller significand, right-shifted by the exponent difference; bit 0 is sticky.
- Special  output  1  result is fully determined by SpecialResult.
- SpecialResult  output  32  final result when Special=1.

Behaviour:
- Reset: RST high at a clock edge clears both stage valid bits and all output registers to 0. A transaction in flight during reset is discarded with no output. InReady reads 1 in the cycle after reset.
- Handshake: a transfer occurs when Valid && Ready. Stage-2 enable is en2 = !V2 || OutReady. Stage-1 enable is en1 = !V1 || en2. InReady = en1 (combinational). Output payload is registered and held stable while OutValid && !OutReady. Full throughput is 1 pair per cycle.
- Latency: 2 cycles from the accept edge to OutValid with no backpressure.
- Stage 1 (classify/order):
  - Effective B sign = Operand2[31] ^ Operation.
  - exp==0 gives hidden bit 0 and effective exponent 1; otherwise hidden bit 1.
  - Compare the magnitudes {exp, frac}. If B > A, swap the operands (B becomes Big). On a tie, A is Big.
  - Compute d = BigExp - SmallExp (unsigned, 8 bits).
- Stage 2 (align): SmallMant = ({hid, frac, GRS zeros} >> d). Bit 0 is then ORed with the OR of all bits shifted out. If d >= MW, SmallMant = 0 except bit 0 = OR of the whole unshifted significand.
- Special cases (decided in stage 1, carried to stage 2):
  - Either operand NaN → SpecialResult = QNAN_PATTERN.
  - Inf with an opposite-signed Inf (effective) → SpecialResult = QNAN_PATTERN.
  - Otherwise, any Inf → that Inf with its effective sign.
  - Both operands zero → ±0, sign = signA AND effective signB.
  - Special=1 forces BigMant = SmallMant = 0 and BigExp = 0; BigSign, SmallSign and EffSub still reflect the inputs.
  - When Special=0, SpecialResult = 0.
- Simultaneous accept and emit in the same cycle is legal; no bubble is inserted.

Optional Feature:
- FPU_ALIGN_DAZ_EN defined: denormals-are-zero. Any operand with exp==0 is treated as signed zero: frac forced to 0, exponent 0. Zero-plus-denormal takes the both-zero special path.
- Undefined: denormals are handled gradually as described above.

Test Plan:
- 0x46BFCA0A + 0x424BEB85, Operation=0 → after 2 cycles: BigExp=0x8D, BigMant=0x5FE5050, SmallMant=0x0032FAF (sticky set), EffSub=0, Special=0.
- 0x3F800000 - 0x3F800000 → BigSign=0, SmallSign=1, EffSub=1, BigMant=SmallMant=0x4000000, BigExp=0x7F.
- 0x4B800000 + 0x3F800001 → SmallMant=0x0000005 (d=24, sticky=1). Then 0x4F800000 + 0x3F800000 → SmallMant=0x0000001 (d=32).
- 0x7F800000 - 0x7F800000 → Special=1, SpecialResult=0x7FC00000. Then 0xFF800000 + 0x3F800000 → SpecialResult=0xFF800000.
- Backpressure: three back-to-back pairs with OutReady=0 → InReady drops to 0 after 2 accepts and output is held stable. Release OutReady → the three results emerge in order on consecutive cycles; no loss or duplication.
- Assert RST while 2 transactions are in flight → OutValid=0 on the next cycle and those transactions never appear. A swapped case with Operand1=0x3F800000, Operand2=0xC0000000, Operation=1 → BigSign=0, BigExp=0x80, SmallSign=0.
